// File: rtl/mips_core.sv
// -----------------------------------------------------------------------------
// mips_core
//   Single-cycle MIPS R-type execution core for ALU/ISA bring-up.
//   Decodes one 32-bit R-type instruction word and reads rs/rt from an
//   internal 32x32 register file. The ALU result is computed combinationally,
//   and it is written back to rd on the rising clock edge.
//   There is no PC, fetch, memory or branch logic.
//
// Ports
//   clk              in   1   rising-edge clock for register-file writeback
//   rst_n            in   1   asynchronous active-low reset (reg[i] <= i)
//   instruction_set  in  32   R-type instruction word
//   result           out 32   ALU result of the current instruction (comb.)
// -----------------------------------------------------------------------------
module mips_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction_set,
  output logic [31:0] result
);

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Instruction fields
  logic [5:0] w_opcode;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic [4:0] w_shamt;
  logic [5:0] w_funct;

  assign w_opcode = instruction_set[31:26];
  assign w_rs     = instruction_set[25:21];
  assign w_rt     = instruction_set[20:16];
  assign w_rd     = instruction_set[15:11];
  assign w_shamt  = instruction_set[10:6];
  assign w_funct  = instruction_set[5:0];

  // Register file. Entry 0 is held at reset value 0 and never written, but the
  // read path also forces it to 0 so reg[0] is hard-wired regardless of state.
  logic [31:0] r_regs [32];

  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;

  assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];

  // ALU and legality decode
  logic [31:0] w_alu;
  logic        w_legal;

  // NOTE: every signal assigned in always_comb gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    w_alu   = 32'd0;
    w_legal = 1'b0;
    if (w_opcode == 6'd0) begin
      w_legal = 1'b1;
      unique case (w_funct)
        FN_ADD,
        FN_ADDU: w_alu = w_rs_val + w_rt_val;   // wraps mod 2^32, no trap
        FN_SUB:  w_alu = w_rs_val - w_rt_val;
        FN_AND:  w_alu = w_rs_val & w_rt_val;
        FN_OR:   w_alu = w_rs_val | w_rt_val;
        FN_SLL:  w_alu = w_rt_val << w_shamt;
        FN_SRL:  w_alu = w_rt_val >> w_shamt;
        FN_SRA:  w_alu = $unsigned($signed(w_rt_val) >>> w_shamt);
        FN_SLTU: w_alu = {31'd0, (w_rs_val < w_rt_val)};
        default: w_legal = 1'b0;                // unlisted funct: result 0
      endcase
    end
  end

  assign result = w_alu;

  // Writeback. Reads see pre-edge contents; there is no bypass path.
  // NOTE: the register file is reset in full because its reset contents
  // (reg[i] = i) are architecturally visible. This is the reason it is built
  // from flops rather than from a RAM macro, which cannot be reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        // NOTE: state is updated with non-blocking assignments so every read in
        // this cycle sees pre-edge values.
        r_regs[i] <= 32'(i);
      end
    end else if (w_legal && (w_rd != 5'd0)) begin
      r_regs[w_rd] <= w_alu;
    end
  end

endmodule

// File: tb/tb_mips_core.sv
// -----------------------------------------------------------------------------
// tb_mips_core
//   Directed self-checking bench for mips_core. Inputs are driven just after the
//   falling edge. Each instruction is therefore held across exactly one rising
//   edge, and a legal instruction writes back exactly once. Outputs are checked
//   1 time unit after every input change or rising edge.
// -----------------------------------------------------------------------------
module tb_mips_core;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction_set;
  logic [31:0] result;

  int n_cmp  = 0;
  int n_fail = 0;

  mips_core dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instruction_set (instruction_set),
    .result          (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh,
                                       input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a new instruction after the falling edge; settle for 1 unit.
  task automatic drive(input logic [31:0] ins);
    @(negedge clk);
    instruction_set = ins;
    #1;
  endtask

  // Let the pending writeback happen and settle.
  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ILLEGAL_OP = 32'h8C43_4820;  // opcode 0x23

  initial begin
    rst_n           = 1'b0;
    instruction_set = ILLEGAL_OP;
    #12;

    // Reset is held, so these reads see reg[i]=i and nothing is written.
    drive(32'h0043_5020); check("add_2_3",   result, 32'd5);
    drive(32'h0067_5021); check("addu_3_7",  result, 32'd10);
    drive(32'h00A4_5022); check("sub_5_4",   result, 32'd1);
    drive(32'h0067_5024); check("and_3_7",   result, 32'd3);
    drive(32'h0067_5025); check("or_3_7",    result, 32'd7);
    drive(32'h01E3_5040); check("sll_3_1",   result, 32'd6);
    drive(32'h00E1_0843); check("sra_1_1",   result, 32'd0);
    drive(32'h02E1_5042); check("srl_1_1",   result, 32'd0);
    drive(32'h0167_502B); check("sltu_11_7", result, 32'd0);
    drive(r_op(5'd7, 5'd11, 5'd0, 5'd0, 6'h2B)); check("sltu_7_11", result, 32'd1);
    drive(ILLEGAL_OP);                         check("illegal_op", result, 32'd0);

    // A legal write to reg10 held across an edge during reset must not land.
    drive(32'h0043_5020);
    edge_settle();
    drive(r_op(5'd10, 5'd0, 5'd0, 5'd0, 6'h20)); check("rst_blocks_wb", result, 32'd10);

    // Release reset with an illegal word so nothing is written.
    drive(ILLEGAL_OP);
    rst_n = 1'b1;

    // Writeback: reg10 <= 5, then 10+7 reads the new value.
    drive(32'h0043_5020); check("wb_add_pre", result, 32'd5);
    drive(32'h0147_5020); check("wb_read_back", result, 32'd12);
    edge_settle();                check("wb_reeval_rd_eq_rs", result, 32'd19);

    // Write attempt to rd=0 is dropped.
    drive(r_op(5'd5, 5'd6, 5'd0, 5'd0, 6'h20)); check("rd0_add", result, 32'd11);
    drive(r_op(5'd0, 5'd4, 5'd0, 5'd0, 6'h20)); check("reg0_zero", result, 32'd4);

    // Sign / overflow: reg8 <= 0 - 1.
    drive(r_op(5'd0, 5'd1, 5'd8, 5'd0, 6'h22)); check("sub_0_1", result, 32'hFFFF_FFFF);
    drive(r_op(5'd0, 5'd8, 5'd0, 5'd4, 6'h03)); check("sra_neg", result, 32'hFFFF_FFFF);
    drive(r_op(5'd0, 5'd8, 5'd0, 5'd4, 6'h02)); check("srl_neg", result, 32'h0FFF_FFFF);
    drive(r_op(5'd0, 5'd8, 5'd0, 5'd31, 6'h00)); check("sll_31", result, 32'h8000_0000);
    drive(r_op(5'd8, 5'd1, 5'd0, 5'd0, 6'h20)); check("add_wrap", result, 32'd0);
    drive(r_op(5'd8, 5'd2, 5'd0, 5'd0, 6'h21)); check("addu_wrap", result, 32'd1);
    drive(r_op(5'd1, 5'd8, 5'd0, 5'd0, 6'h2B)); check("sltu_big", result, 32'd1);
    drive(r_op(5'd8, 5'd1, 5'd0, 5'd0, 6'h2B)); check("sltu_unsigned", result, 32'd0);

    // Illegal opcode and illegal funct aimed at rd=9: result 0, no write.
    drive({6'h23, 5'd2, 5'd3, 5'd9, 5'd0, 6'h20}); check("bad_opcode", result, 32'd0);
    drive(r_op(5'd2, 5'd3, 5'd9, 5'd0, 6'h26));   check("bad_funct", result, 32'd0);
    drive(r_op(5'd9, 5'd0, 5'd0, 5'd0, 6'h20));   check("reg9_kept", result, 32'd9);

    // Mid-sequence reset: reg6 <= 9, then reset mid-cycle restores reg[i]=i.
    drive(r_op(5'd4, 5'd5, 5'd6, 5'd0, 6'h20));   check("add_4_5", result, 32'd9);
    drive(r_op(5'd6, 5'd0, 5'd0, 5'd0, 6'h20));   check("reg6_written", result, 32'd9);
    #2;
    rst_n = 1'b0;
    #1;                                           check("async_rst_reg6", result, 32'd6);
    instruction_set = r_op(5'd8, 5'd0, 5'd0, 5'd0, 6'h20);
    #1;                                           check("async_rst_reg8", result, 32'd8);
    instruction_set = r_op(5'd10, 5'd0, 5'd0, 5'd0, 6'h20);
    #1;                                           check("async_rst_reg10", result, 32'd10);

    // Reset asserted on a rising edge while a legal write is pending.
    drive(ILLEGAL_OP);
    rst_n = 1'b1;
    drive(r_op(5'd2, 5'd3, 5'd10, 5'd0, 6'h20));  check("pre_coincident", result, 32'd5);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    instruction_set = r_op(5'd10, 5'd0, 5'd0, 5'd0, 6'h20);
    #1;                                           check("rst_wins_edge", result, 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
